// File: rtl/inversemapping_table_manager_pkg.sv
// inversemapping_table_manager_pkg: shared widths, entry field offsets and table-manager FSM states.
package inversemapping_table_manager_pkg;
    localparam int TABLE_DEPTH = 256;
    localparam int ENTRY_W     = 62;
    localparam int ADDR_W      = 8;
    localparam int FLOWID_LSB  = 48;
    localparam int FLOWID_W    = 14;
    localparam int DMAC_LSB    = 0;
    localparam int DMAC_W      = 48;

    typedef enum logic [2:0] {
        IDLE, CFG_WR, CFG_RD, RD_WAIT1, RD_WAIT2, CLEAR
    } state_t;
endpackage

// File: rtl/inversemapping_table_manager_if.sv
// inversemapping_table_manager_if: configuration register bus of the regroup table.
interface inversemapping_table_manager_if;
    import inversemapping_table_manager_pkg::*;
    logic               i_cfg_wr;
    logic               i_cfg_rd;
    logic [ADDR_W-1:0]  iv_cfg_addr;
    logic [ENTRY_W-1:0] iv_cfg_wdata;
    logic               o_cfg_ack;
    logic [ENTRY_W-1:0] ov_cfg_rdata;
    logic               o_cfg_rdata_valid;
    logic               o_cfg_busy;

    modport master (
        output i_cfg_wr, i_cfg_rd, iv_cfg_addr, iv_cfg_wdata,
        input  o_cfg_ack, ov_cfg_rdata, o_cfg_rdata_valid, o_cfg_busy
    );
    modport slave (
        input  i_cfg_wr, i_cfg_rd, iv_cfg_addr, iv_cfg_wdata,
        output o_cfg_ack, ov_cfg_rdata, o_cfg_rdata_valid, o_cfg_busy
    );
endinterface

// File: rtl/inversemapping_table_manager.sv
// inversemapping_table_manager: shares the regroup-table RAM port between lookup, config access and bulk clear.
module inversemapping_table_manager
    import inversemapping_table_manager_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_lookup_rd,
    input  logic [ADDR_W-1:0]    iv_lookup_raddr,
    output logic [ENTRY_W-1:0]   ov_lookup_rdata,
    inversemapping_table_manager_if.slave cfg,
    input  logic                 i_table_clear,
    output logic                 o_clear_done,
    output logic                 o_table_busy,
    output logic                 o_ram_rd,
    output logic                 o_ram_wr,
    output logic [ADDR_W-1:0]    ov_ram_addr,
    output logic [ENTRY_W-1:0]   ov_ram_wdata,
    input  logic [ENTRY_W-1:0]   iv_ram_rdata
);
    state_t             state, state_nx;
    logic [ADDR_W:0]    clr_cnt;
    logic [ADDR_W-1:0]  req_addr;
    logic [ENTRY_W-1:0] req_data;
    logic               clr_last;

    assign clr_last               = clr_cnt == (ADDR_W+1)'(TABLE_DEPTH-1);
    assign ov_lookup_rdata        = iv_ram_rdata;
    assign cfg.o_cfg_busy         = state != IDLE;
    assign cfg.o_cfg_rdata_valid  = state == RD_WAIT2;
    assign o_table_busy           = state == CLEAR;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            clr_cnt          <= '0;
            req_addr         <= '0;
            req_data         <= '0;
            cfg.ov_cfg_rdata <= '0;
        end else begin
            state <= state_nx;
            // request fields are sampled every idle cycle; only the accepting cycle's copy is ever used
            if (state == IDLE) begin
                req_addr <= cfg.iv_cfg_addr;
                req_data <= cfg.iv_cfg_wdata;
                clr_cnt  <= '0;
            end else if (state == CLEAR && !i_lookup_rd) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (state == RD_WAIT2) cfg.ov_cfg_rdata <= iv_ram_rdata;
        end
    end

    always_comb begin
        state_nx      = state;
        o_ram_rd      = i_lookup_rd;
        o_ram_wr      = 1'b0;
        ov_ram_addr   = i_lookup_rd ? iv_lookup_raddr : '0;
        ov_ram_wdata  = '0;
        cfg.o_cfg_ack = 1'b0;
        o_clear_done  = 1'b0;
        case (state)
            IDLE:     state_nx = i_table_clear ? CLEAR : cfg.i_cfg_wr ? CFG_WR : cfg.i_cfg_rd ? CFG_RD : IDLE;
            CFG_WR: if (!i_lookup_rd) begin
                o_ram_wr      = 1'b1;
                ov_ram_addr   = req_addr;
                ov_ram_wdata  = req_data;
                cfg.o_cfg_ack = 1'b1;
                state_nx      = IDLE;
            end
            CFG_RD: if (!i_lookup_rd) begin
                o_ram_rd      = 1'b1;
                ov_ram_addr   = req_addr;
                cfg.o_cfg_ack = 1'b1;
                state_nx      = RD_WAIT1;
            end
            RD_WAIT1: state_nx = RD_WAIT2;
            RD_WAIT2: state_nx = IDLE;
            CLEAR: if (!i_lookup_rd) begin
                o_ram_wr     = 1'b1;
                ov_ram_addr  = clr_cnt[ADDR_W-1:0];
                o_clear_done = clr_last;
                state_nx     = clr_last ? IDLE : CLEAR;
            end
            default:  state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_inversemapping_table_manager.sv
// tb_inversemapping_table_manager: random and directed traffic against an abstract table/RAM-port model.
module tb_inversemapping_table_manager;
    import inversemapping_table_manager_pkg::*;

    localparam int K_WR = 0, K_RD = 1, K_CLR = 2;

    typedef struct {
        int                 kind;
        logic [ADDR_W-1:0]  addr;
        logic [ENTRY_W-1:0] data;
        int                 t;
    } op_t;
    typedef struct {
        int                 t;
        logic [ENTRY_W-1:0] d;
    } ev_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               lookup_rd = 1'b0;
    logic [ADDR_W-1:0]  lookup_raddr = '0;
    logic [ENTRY_W-1:0] lookup_rdata;
    logic               table_clear = 1'b0;
    logic               clear_done, table_busy, ram_rd, ram_wr;
    logic [ADDR_W-1:0]  ram_addr;
    logic [ENTRY_W-1:0] ram_wdata;
    bit   [ENTRY_W-1:0] ram_rdata;

    bit   [ENTRY_W-1:0] mem [TABLE_DEPTH];
    bit   [ENTRY_W-1:0] mdl [TABLE_DEPTH];
    logic [ADDR_W-1:0]  ram_a1;

    op_t  ops[$];
    ev_t  rdq[$];
    ev_t  lkq[$];
    int   clr_k = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rd_chk_pend = 0;
    int   rd_chk_t = 0;
    logic [ENTRY_W-1:0] rd_chk_d = '0;

    inversemapping_table_manager_if cfg_if();

    inversemapping_table_manager dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_lookup_rd     (lookup_rd),
        .iv_lookup_raddr (lookup_raddr),
        .ov_lookup_rdata (lookup_rdata),
        .cfg             (cfg_if),
        .i_table_clear   (table_clear),
        .o_clear_done    (clear_done),
        .o_table_busy    (table_busy),
        .o_ram_rd        (ram_rd),
        .o_ram_wr        (ram_wr),
        .ov_ram_addr     (ram_addr),
        .ov_ram_wdata    (ram_wdata),
        .iv_ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // table RAM with two-cycle read latency
    always @(posedge clk) begin
        ram_a1    <= ram_addr;
        ram_rdata <= mem[ram_a1];
        if (ram_wr) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit model_busy();
        return ops.size() != 0 || rdq.size() != 0;
    endfunction

    // monitor: the accepted operation runs on the first cycle the lookup leaves free
    always @(negedge clk) begin : mon
        bit e_wr, e_rd, e_ack, e_done, e_tbusy, e_cbusy, e_valid, active;
        logic [ADDR_W-1:0]  e_addr;
        logic [ENTRY_W-1:0] e_wd;
        if (!rst_n) begin
            ops.delete(); rdq.delete(); lkq.delete();
            clr_k = 0; rd_chk_pend = 0;
        end else begin
            e_wr = 0; e_rd = 0; e_ack = 0; e_done = 0; e_valid = 0;
            e_addr = '0; e_wd = '0;
            active  = ops.size() > 0 && cyc > ops[0].t;
            e_cbusy = active || rdq.size() > 0;
            e_tbusy = active && ops[0].kind == K_CLR;
            if (lookup_rd) begin
                e_rd = 1; e_addr = lookup_raddr;
                lkq.push_back('{cyc + 2, mdl[lookup_raddr]});
            end else if (active) begin
                if (ops[0].kind == K_WR) begin
                    e_wr = 1; e_ack = 1; e_addr = ops[0].addr; e_wd = ops[0].data;
                    mdl[ops[0].addr] = ops[0].data;
                    void'(ops.pop_front());
                end else if (ops[0].kind == K_RD) begin
                    e_rd = 1; e_ack = 1; e_addr = ops[0].addr;
                    rdq.push_back('{cyc + 2, mdl[ops[0].addr]});
                    void'(ops.pop_front());
                end else begin
                    e_wr = 1; e_addr = ADDR_W'(clr_k);
                    mdl[clr_k] = '0;
                    e_done = clr_k == TABLE_DEPTH - 1;
                    if (e_done) begin
                        clr_k = 0;
                        void'(ops.pop_front());
                    end else clr_k++;
                end
            end
            if (rdq.size() > 0 && rdq[0].t == cyc) begin
                e_valid = 1;
                rd_chk_pend = 1; rd_chk_t = cyc + 1; rd_chk_d = rdq[0].d;
                void'(rdq.pop_front());
            end else if (rd_chk_pend && rd_chk_t == cyc) begin
                chk("cfg_rdata", 64'(cfg_if.ov_cfg_rdata), 64'(rd_chk_d));
                rd_chk_pend = 0;
            end
            if (lkq.size() > 0 && lkq[0].t == cyc) begin
                chk("lookup_rdata", 64'(lookup_rdata), 64'(lkq[0].d));
                void'(lkq.pop_front());
            end
            chk("ram_rd", 64'(ram_rd), 64'(e_rd));
            chk("ram_wr", 64'(ram_wr), 64'(e_wr));
            if (e_rd || e_wr) chk("ram_addr", 64'(ram_addr), 64'(e_addr));
            if (e_wr) chk("ram_wdata", 64'(ram_wdata), 64'(e_wd));
            chk("cfg_ack", 64'(cfg_if.o_cfg_ack), 64'(e_ack));
            chk("clear_done", 64'(clear_done), 64'(e_done));
            chk("table_busy", 64'(table_busy), 64'(e_tbusy));
            chk("cfg_busy", 64'(cfg_if.o_cfg_busy), 64'(e_cbusy));
            chk("rdata_valid", 64'(cfg_if.o_cfg_rdata_valid), 64'(e_valid));
        end
    end

    // drive one cycle; a request is accepted only when the model says the block is idle
    task automatic step(input bit lk, input logic [ADDR_W-1:0] la, input bit wr, input bit rd,
                        input bit clr, input logic [ADDR_W-1:0] a, input logic [ENTRY_W-1:0] d);
        @(posedge clk); #1;
        lookup_rd = lk; lookup_raddr = la;
        cfg_if.i_cfg_wr = wr; cfg_if.i_cfg_rd = rd; table_clear = clr;
        cfg_if.iv_cfg_addr = a; cfg_if.iv_cfg_wdata = d;
        if (!model_busy()) begin
            if (clr)     ops.push_back('{K_CLR, '0, '0, cyc});
            else if (wr) ops.push_back('{K_WR, a, d, cyc});
            else if (rd) ops.push_back('{K_RD, a, '0, cyc});
        end
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0, '0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while (model_busy() && n < 2000) begin idle(); n++; end
        if (model_busy()) begin
            failures++;
            $display("FAIL drain_timeout cyc=%0d actual=busy expected=idle", cyc);
        end
        repeat (3) idle();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_if.i_cfg_wr = 0; cfg_if.i_cfg_rd = 0;
        cfg_if.iv_cfg_addr = '0; cfg_if.iv_cfg_wdata = '0;
        #1;
        chk("rst_ram_wr", 64'(ram_wr), 0);
        chk("rst_ram_rd", 64'(ram_rd), 0);
        chk("rst_cfg_busy", 64'(cfg_if.o_cfg_busy), 0);
        chk("rst_table_busy", 64'(table_busy), 0);
        chk("rst_cfg_rdata", 64'(cfg_if.ov_cfg_rdata), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // write then read back a flowid/dmac entry
        step(0, '0, 1, 0, 0, 8'h05, {14'h0123, 48'h0A0B0C0D0E0F});
        drain();
        step(0, '0, 0, 1, 0, 8'h05, '0);
        drain();

        // write stalled behind four lookup cycles
        step(1, 8'h31, 1, 0, 0, 8'h10, 62'h2AAA_5555_1234_9876);
        step(1, 8'h32, 0, 0, 0, '0, '0);
        step(1, 8'h33, 0, 0, 0, '0, '0);
        step(1, 8'h05, 0, 0, 0, '0, '0);
        drain();

        // bulk clear, then boundary reads
        step(0, '0, 0, 0, 1, '0, '0);
        drain();
        step(0, '0, 0, 1, 0, 8'h00, '0);
        drain();
        step(0, '0, 0, 1, 0, 8'hFF, '0);
        drain();

        // clear and write together: the write is dropped
        step(0, '0, 1, 0, 1, 8'h40, 62'h3);
        drain();
        step(0, '0, 0, 1, 0, 8'h40, '0);
        drain();

        // simultaneous write and read: only the write happens
        step(0, '0, 1, 1, 0, 8'h20, 62'h1);
        drain();
        step(0, '0, 0, 1, 0, 8'h20, '0);
        drain();

        // random mix, including requests that arrive while busy
        for (int i = 0; i < 1500; i++) begin
            int r = int'($urandom_range(0, 99));
            step($urandom_range(0, 2) == 0, ADDR_W'($urandom()),
                 r < 8, r >= 8 && r < 16, r == 99,
                 ADDR_W'($urandom_range(0, 15)), ENTRY_W'({$urandom(), $urandom()}));
        end
        drain();

        // reset in the middle of a sweep
        step(0, '0, 0, 0, 1, '0, '0);
        for (int i = 0; i < 400 && clr_k != 100; i++) idle();
        #2;
        chk("mid_clear_addr", 64'(ram_addr), 64'd100);
        rst_n = 0;
        #1;
        chk("midrst_ram_wr", 64'(ram_wr), 0);
        chk("midrst_ram_addr", 64'(ram_addr), 0);
        chk("midrst_clear_done", 64'(clear_done), 0);
        chk("midrst_table_busy", 64'(table_busy), 0);
        chk("midrst_cfg_busy", 64'(cfg_if.o_cfg_busy), 0);
        chk("midrst_cfg_rdata", 64'(cfg_if.ov_cfg_rdata), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (10) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
